// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage.
// Optional misaligned-PC trapping is enabled by FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int FETCH_DEPTH  = 2;
    localparam int FETCH_ADDR_W = 32;

    // Queue entry layout: {pc, instruction word, fault}
    localparam int FETCH_ENTRY_W = FETCH_ADDR_W + 32 + 1;

    function automatic int entry_w(input int addr_w);
        return addr_w + 32 + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched words for decode.
// Clear has priority over push and pop; popping an empty queue is ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int WIDTH = FETCH_ENTRY_W,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             Push,
    input  logic [WIDTH-1:0] Push_Data,
    input  logic             Pop,
    output logic [WIDTH-1:0] Head,
    output logic [CW-1:0]    Count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = Pop & (Count != '0);
    assign do_push = Push & ((Count < FULL) | do_pop);
    assign Head    = mem[rd_ptr];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else if (Clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= Push_Data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            Count <= Count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory read, result queue, flush.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned PCs instead of masking them.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int ADDR_W = FETCH_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Pc_In,
    input  logic              Pc_Valid,
    output logic              Pc_Ready,
    input  logic              Flush,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [31:0]       Mem_Rdata,
    output logic              Instr_Valid,
    input  logic              Dec_Ready,
    output logic [31:0]       Instr_Out,
    output logic [ADDR_W-1:0] Instr_Pc,
    output logic              Instr_Fault
);

    localparam int EW = entry_w(ADDR_W);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic [EW-1:0]     push_data;
    logic              push;
    logic              accept;
    logic              issue;
    logic              fault_push;
    logic [ADDR_W-1:0] req_pc;

    assign Pc_Ready = (state_q == IDLE) & (count < FULL) & ~Flush;
    assign accept   = Pc_Valid & Pc_Ready;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign;
    assign misalign   = Pc_In[1:0] != 2'b00;
    assign issue      = accept & ~misalign;
    assign fault_push = accept & misalign;
    assign req_pc     = Pc_In;
`else
    assign issue      = accept;
    assign fault_push = 1'b0;
    assign req_pc     = Pc_In & ~ADDR_W'(3);
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        push      = 1'b0;
        push_data = {addr_q, Mem_Rdata, 1'b0};
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    addr_d  = req_pc;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end else if (fault_push) begin
                    push      = 1'b1;
                    push_data = {Pc_In, 32'h0, 1'b1};
                end
            end
            WAIT: begin
                if (Mem_Ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    push    = ~Flush;
                end else if (Flush) begin
                    state_d = DRAIN;
                end
            end
            // The handshake is never abandoned; the late word is dropped.
            DRAIN: begin
                if (Mem_Ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .Clr       (Flush),
        .Push      (push),
        .Push_Data (push_data),
        .Pop       (Dec_Ready & ~Flush),
        .Head      (head),
        .Count     (count)
    );

    assign Mem_Req     = req_q;
    assign Mem_Addr    = addr_q;
    assign Instr_Valid = count != '0;
    assign Instr_Pc    = head[EW-1 -: ADDR_W];
    assign Instr_Out   = head[32:1];
    assign Instr_Fault = head[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
// Honors FETCH_ALIGN_CHECK_EN in its model when the RTL is built with it.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Pc_In;
    logic        Pc_Valid;
    logic        Pc_Ready;
    logic        Flush;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack;
    logic [31:0] Mem_Rdata;
    logic        Instr_Valid;
    logic        Dec_Ready;
    logic [31:0] Instr_Out;
    logic [31:0] Instr_Pc;
    logic        Instr_Fault;

    fetch_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (32)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Pc_In       (Pc_In),
        .Pc_Valid    (Pc_Valid),
        .Pc_Ready    (Pc_Ready),
        .Flush       (Flush),
        .Mem_Req     (Mem_Req),
        .Mem_Addr    (Mem_Addr),
        .Mem_Ack     (Mem_Ack),
        .Mem_Rdata   (Mem_Rdata),
        .Instr_Valid (Instr_Valid),
        .Dec_Ready   (Dec_Ready),
        .Instr_Out   (Instr_Out),
        .Instr_Pc    (Instr_Pc),
        .Instr_Fault (Instr_Fault)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        fault;
    } ent_t;

    ent_t        q[$];
    bit          busy;
    bit          doomed;
    logic [31:0] req_addr;

    task automatic check_outputs();
        chk("mem_req", Mem_Req, busy);
        if (busy) chk("mem_addr", Mem_Addr, req_addr);
        chk("instr_valid", Instr_Valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("instr_pc", Instr_Pc, q[0].pc);
            chk("instr_out", Instr_Out, q[0].word);
            chk("instr_fault", Instr_Fault, q[0].fault);
        end
    endtask

    initial begin
        bit   exp_ready, acc, mis, pop;
        ent_t e;
        Reset     = 1'b0;
        Pc_In     = '0;
        Pc_Valid  = 1'b0;
        Flush     = 1'b0;
        Mem_Ack   = 1'b0;
        Mem_Rdata = '0;
        Dec_Ready = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_mem_req", Mem_Req, 0);
        chk("rst_mem_addr", Mem_Addr, 0);
        chk("rst_valid", Instr_Valid, 0);
        chk("rst_out", Instr_Out, 0);
        chk("rst_pc", Instr_Pc, 0);
        chk("rst_fault", Instr_Fault, 0);
        Reset = 1'b1;

        // Reset asserted while a request is outstanding.
        @(negedge Clk);
        Pc_Valid = 1'b1;
        Pc_In    = 32'h40;
        @(posedge Clk);
        #1 Pc_Valid = 1'b0;
        chk("wait_req", Mem_Req, 1);
        chk("wait_addr", Mem_Addr, 32'h40);
        chk("wait_ready", Pc_Ready, 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("midrst_req", Mem_Req, 0);
        chk("midrst_addr", Mem_Addr, 0);
        chk("midrst_valid", Instr_Valid, 0);
        @(negedge Clk);
        Reset = 1'b1;
        #1 chk("post_rst_ready", Pc_Ready, 1);

        q.delete();
        busy     = 0;
        doomed   = 0;
        req_addr = '0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            check_outputs();
            Pc_Valid  = $urandom_range(9, 0) < 7;
            Pc_In     = {$urandom_range(255, 0), 2'b00}
                        | 32'($urandom_range(3, 0) == 0 ? $urandom_range(3, 1) : 0);
            Flush     = $urandom_range(11, 0) == 0;
            Dec_Ready = $urandom_range(9, 0) < 5;
            Mem_Ack   = busy && ($urandom_range(1, 0) == 1);
            Mem_Rdata = $urandom;
            #1;
            exp_ready = !busy && q.size() < DEPTH && !Flush;
            chk("pc_ready", Pc_Ready, exp_ready);

            acc = Pc_Valid && exp_ready;
            pop = Dec_Ready && !Flush && q.size() > 0;
`ifdef FETCH_ALIGN_CHECK_EN
            mis = Pc_In[1:0] != 2'b00;
`else
            mis = 0;
`endif
            if (Flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (busy && Mem_Ack && !doomed) begin
                    e.pc = req_addr; e.word = Mem_Rdata; e.fault = 0;
                    q.push_back(e);
                end
                if (acc && mis) begin
                    e.pc = Pc_In; e.word = 0; e.fault = 1;
                    q.push_back(e);
                end
            end
            if (busy && Mem_Ack) begin
                busy   = 0;
                doomed = 0;
            end else if (busy && Flush) begin
                doomed = 1;
            end
            if (acc && !mis) begin
                busy = 1;
`ifdef FETCH_ALIGN_CHECK_EN
                req_addr = Pc_In;
`else
                req_addr = Pc_In & 32'hFFFF_FFFC;
`endif
            end
            @(posedge Clk);
            @(negedge Clk);
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the PC register. Accepts the current PC, issues a single-outstanding-request read to instruction memory with a req/ack handshake, and buffers returned words with their PC in a small queue for decode. Backpressures the PC stage via `Pc_Ready` and discards wrong-path fetches on `Flush` from branch/jump resolution.

## Interface
- `DEPTH`, 2: queue entries; power of two, ≥2.
- `ADDR_W`, 32: PC/address width.
- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Pc_In`  in  ADDR_W  PC from PC register.
- `Pc_Valid`  in  1  `Pc_In` holds a PC to fetch.
- `Pc_Ready`  out  1  PC accepted this cycle when `Pc_Valid & Pc_Ready`; PC stage holds when low.
- `Flush`  in  1  redirect; discard queued and in-flight fetches.
- `Mem_Req`  out  1  read request to instruction memory.
- `Mem_Addr`  out  ADDR_W  word address of request.
- `Mem_Ack`  in  1  read complete; `Mem_Rdata` valid this cycle.
- `Mem_Rdata`  in  32  instruction word.
- `Instr_Valid`  out  1  queue head valid.
- `Dec_Ready`  in  1  decode pops head when `Instr_Valid & Dec_Ready`.
- `Instr_Out`  out  32  head instruction.
- `Instr_Pc`  out  ADDR_W  PC of head instruction.
- `Instr_Fault`  out  1  head came from a misaligned PC.

## Operation
- States: IDLE, WAIT, DRAIN.
- `Pc_Ready = (state==IDLE) & (count<DEPTH) & ~Flush` (combinational).
- IDLE: on accept, register `Mem_Addr <= Pc_In`, `Mem_Req <= 1`, go WAIT.
- WAIT: `Mem_Req`, `Mem_Addr` held stable until `Mem_Ack`. On `Mem_Ack & ~Flush`: push {`Mem_Addr`, `Mem_Rdata`, fault=0}, drop `Mem_Req`, go IDLE. On `Flush & ~Mem_Ack`: go DRAIN. On `Flush & Mem_Ack`: data discarded, go IDLE.
- DRAIN: `Mem_Req` held (handshake never abandoned); on `Mem_Ack` discard data, go IDLE. `Flush` in DRAIN: stay DRAIN.
- `Flush` (any state): queue cleared same edge; `Instr_Valid` low next cycle; a pop in the flush cycle is ignored.
- Queue cannot overflow: accept needs `count<DEPTH` with zero outstanding; push and pop in the same cycle both take effect; pop when empty ignored.
- Reset: state IDLE, queue empty, `Mem_Req`=0, `Mem_Addr`=0, `Instr_Valid`=0, `Instr_Out`=0, `Instr_Pc`=0, `Instr_Fault`=0. Reset mid-handshake drops `Mem_Req` immediately; memory must tolerate the abort.

## Timing
- Accept at edge N → `Mem_Req` high in cycle N+1.
- `Mem_Ack` earliest in cycle N+1 (zero-wait memory); ack in cycle M → `Instr_Valid` high in cycle M+1 with that word at head.
- Zero-wait throughput: one instruction per 2 cycles (IDLE/WAIT alternation).
- Outputs `Mem_*`, `Instr_*` registered; `Pc_Ready` combinational from state, count, `Flush`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: an accepted PC with `Pc_In[1:0]!=0` issues no memory request; pushes {PC, `Instr_Out`=0, fault=1} directly in the accept cycle, state stays IDLE.
- Undefined: `Mem_Addr[1:0]` forced to 0, misalignment ignored, `Instr_Fault` tied 0.

## Structure
- Package `fetch_pkg`: state enum (IDLE/WAIT/DRAIN), default `DEPTH`, entry-width constant (ADDR_W+32+1).
- Sub-module `fetch_fifo`: DEPTH-entry synchronous FIFO with push, pop, synchronous clear, count; `fetch_unit` holds FSM and request registers.

## Test plan
- Reset low mid-WAIT with `Mem_Req`=1 → all outputs 0, state IDLE, `Pc_Ready`=1 after release.
- `Pc_In`=0x00000000, 0x4, 0x8 with zero-wait memory, `Dec_Ready`=1 → `Mem_Addr` 0x0, 0x4, 0x8; decode sees (0x0,word0),(0x4,word1),(0x8,word2) in order.
- `Dec_Ready`=0, DEPTH=2, PCs 0x10, 0x14, 0x18 → two entries queued, `Pc_Ready`=0 with 0x18 held; one pop → 0x18 fetched.
- `Flush` in WAIT for 0x20, `Mem_Ack` 3 cycles later → `Mem_Req` held until ack, no push, queue empty, next PC 0x100 fetched normally.
- `Flush` coincident with `Mem_Ack` and a pop → nothing pushed, queue empty next cycle, `Instr_Valid`=0.
- With `FETCH_ALIGN_CHECK_EN`, `Pc_In`=0x22 → no `Mem_Req`; head `Instr_Pc`=0x22, `Instr_Out`=0, `Instr_Fault`=1 next cycle.
